// File: rtl/alu_divrem_iter_pkg.sv
// Shared ALU definitions for the divide/remainder unit.
// Contents: opcode constants, result-flag bit indices, FSM state type and an
// opcode legality helper.
package alu_divrem_iter_pkg;

    localparam logic [3:0] OP_DIV = 4'h6;
    localparam logic [3:0] OP_REM = 4'h7;

    // Bit positions within the 4-bit ALU flag vector.
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_OVER  = 2;
    localparam int unsigned FLAG_CARRY = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_divrem_iter_if.sv
// Dispatch interface between the ALU dispatcher (master) and the divide
// sub-unit (slave).
// Signals: data_valid/opcode/data_a/data_b (request), result/result_valid/
// result_flags (completion), busy (sub-unit occupied).
interface alu_divrem_iter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;
    logic [3:0]            result_flags;
    logic                  busy;

    modport master (
        output data_valid, opcode, data_a, data_b,
        input  result, result_valid, result_flags, busy
    );

    modport slave (
        input  data_valid, opcode, data_a, data_b,
        output result, result_valid, result_flags, busy
    );
endinterface

// File: rtl/alu_divrem_step.sv
// One combinational restoring-division step.
// Ports: rem_i/quo_i/divisor_i - current partial remainder, quotient/dividend
// shift register and divisor; rem_o/quo_o - values after the step.
// The dividend is consumed MSB-first from quo_i while quotient bits enter at
// the LSB, so after DATA_WIDTH steps quo holds the quotient and rem the remainder.
module alu_divrem_step #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  fits;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        // When the divisor fits the true difference is below the divisor, so the
        // low DATA_WIDTH bits of the subtraction are exact.
        diff    = shifted[DATA_WIDTH-1:0] - divisor_i;
        rem_o   = fits ? diff : shifted[DATA_WIDTH-1:0];
        quo_o   = {quo_i[DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/alu_divrem_iter.sv
// Multi-cycle unsigned divide/remainder execution unit.
// Ports: clk, reset_n (async active-low), bus (slave side of the dispatch
// interface: start strobe, opcode, operands in; result, result_valid pulse,
// result_flags and busy out).
// SINGLE_CYCLE = 0 iterates one quotient bit per clock; SINGLE_CYCLE = 1 uses
// a chained array of steps evaluated in the DONE cycle.
module alu_divrem_iter
    import alu_divrem_iter_pkg::*;
#(
    parameter int unsigned SINGLE_CYCLE = 0,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input logic              clk,
    input logic              reset_n,
    alu_divrem_iter_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [3:0]            flags_q, flags_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] step_rem, step_quo;
    logic [DATA_WIDTH-1:0] fin_rem, fin_quo;
    logic [DATA_WIDTH-1:0] fin_result;
    logic [3:0]            fin_flags;
    logic                  div_zero, legal;

    alu_divrem_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(div_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    generate
        if (SINGLE_CYCLE != 0) begin : gen_array
            logic [DATA_WIDTH-1:0] chain_rem [DATA_WIDTH+1];
            logic [DATA_WIDTH-1:0] chain_quo [DATA_WIDTH+1];

            assign chain_rem[0] = rem_q;
            assign chain_quo[0] = quo_q;

            for (genvar i = 0; i < DATA_WIDTH; i++) begin : gen_stage
                alu_divrem_step #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_stage (
                    .rem_i    (chain_rem[i]),
                    .quo_i    (chain_quo[i]),
                    .divisor_i(div_q),
                    .rem_o    (chain_rem[i+1]),
                    .quo_o    (chain_quo[i+1])
                );
            end

            assign fin_rem = chain_rem[DATA_WIDTH];
            assign fin_quo = chain_quo[DATA_WIDTH];
        end else begin : gen_iter
            assign fin_rem = rem_q;
            assign fin_quo = quo_q;
        end
    endgenerate

    // Final result selection from the latched operation.
    always_comb begin
        legal      = op_is_legal(op_q);
        div_zero   = (div_q == '0);
        fin_result = '0;
        if (legal) begin
            if (div_zero) begin
                // quo_q still holds the untouched dividend here.
                fin_result = (op_q == OP_DIV) ? '1 : quo_q;
            end else begin
                fin_result = (op_q == OP_DIV) ? fin_quo : fin_rem;
            end
        end
        fin_flags             = '0;
        fin_flags[FLAG_ZERO]  = (fin_result == '0);
        fin_flags[FLAG_NEG]   = fin_result[DATA_WIDTH-1];
        fin_flags[FLAG_OVER]  = legal && div_zero;
        fin_flags[FLAG_CARRY] = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.data_valid) begin
                    op_d  = bus.opcode;
                    quo_d = bus.data_a;
                    div_d = bus.data_b;
                    rem_d = '0;
                    cnt_d = CntW'(DATA_WIDTH - 1);
                    if ((SINGLE_CYCLE == 0) && op_is_legal(bus.opcode) &&
                        (bus.data_b != '0)) begin
                        state_d = StIter;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIter: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = fin_result;
                flags_d  = fin_flags;
                valid_d  = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_flags = flags_q;
    assign bus.result_valid = valid_q;
    // The result pulse is issued as the FSM returns to idle, so busy covers it.
    assign bus.busy         = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_alu_divrem_iter.sv
// Directed and random checks of alu_divrem_iter in iterative and single-cycle
// configurations with DATA_WIDTH = 8.
module tb_alu_divrem_iter;
    import alu_divrem_iter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_divrem_iter_if #(.DATA_WIDTH(8)) bus_it ();
    alu_divrem_iter_if #(.DATA_WIDTH(8)) bus_sc ();

    alu_divrem_iter #(
        .SINGLE_CYCLE(0),
        .DATA_WIDTH  (8)
    ) u_dut_iter (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_it.slave)
    );

    alu_divrem_iter #(
        .SINGLE_CYCLE(1),
        .DATA_WIDTH  (8)
    ) u_dut_sc (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_sc.slave)
    );

    function automatic logic [7:0] model_res(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        if (op != OP_DIV && op != OP_REM) return 8'h00;
        if (b == 8'h00) return (op == OP_DIV) ? 8'hFF : a;
        return (op == OP_DIV) ? a / b : a % b;
    endfunction

    function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
        logic [7:0] r;
        logic       ovf;
        r   = model_res(op, a, b);
        ovf = (op == OP_DIV || op == OP_REM) && (b == 8'h00);
        return {1'b0, ovf, r[7], (r == 8'h00)};
    endfunction

    // Issues one operation with a one-cycle strobe, scrambles the operands after
    // acceptance and waits (bounded) for the completion pulse. lat = -1 on timeout.
    task automatic run_op(input bit sc, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, output logic [7:0] res,
                          output logic [3:0] flg, output int lat, output int busy_n);
        logic v, bz;
        @(negedge clk);
        if (sc) begin
            bus_sc.data_valid = 1'b1; bus_sc.opcode = op; bus_sc.data_a = a; bus_sc.data_b = b;
        end else begin
            bus_it.data_valid = 1'b1; bus_it.opcode = op; bus_it.data_a = a; bus_it.data_b = b;
        end
        @(posedge clk);
        @(negedge clk);
        if (sc) begin
            bus_sc.data_valid = 1'b0; bus_sc.opcode = 4'h0; bus_sc.data_a = ~a; bus_sc.data_b = ~b;
        end else begin
            bus_it.data_valid = 1'b0; bus_it.opcode = 4'h0; bus_it.data_a = ~a; bus_it.data_b = ~b;
        end
        lat = -1; busy_n = 0; res = 8'h00; flg = 4'h0;
        for (int k = 0; k < 40; k++) begin
            v  = sc ? bus_sc.result_valid : bus_it.result_valid;
            bz = sc ? bus_sc.busy : bus_it.busy;
            if (bz) busy_n++;
            if (v) begin
                lat = k;
                res = sc ? bus_sc.result : bus_it.result;
                flg = sc ? bus_sc.result_flags : bus_it.result_flags;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            checks++;
            if ({bus_it.result, bus_it.result_flags, bus_it.result_valid, bus_it.busy} !== 14'h0) begin
                failures++;
                $display("FAIL reset_iter pass%0d: got res=%h flg=%b v=%b busy=%b expected all 0",
                         pass, bus_it.result, bus_it.result_flags, bus_it.result_valid, bus_it.busy);
            end
            checks++;
            if ({bus_sc.result, bus_sc.result_flags, bus_sc.result_valid, bus_sc.busy} !== 14'h0) begin
                failures++;
                $display("FAIL reset_sc pass%0d: got res=%h flg=%b v=%b busy=%b expected all 0",
                         pass, bus_sc.result, bus_sc.result_flags, bus_sc.result_valid, bus_sc.busy);
            end
            reset_n = 1'b1;
        end
    endtask

    task automatic test_div();
        logic [7:0] res; logic [3:0] flg; int lat, bn;
        run_op(1'b0, OP_DIV, 8'd100, 8'd7, res, flg, lat, bn);
        checks++;
        if (res !== 8'h0E) begin failures++; $display("FAIL div100_7 result: got %h expected 0e", res); end
        checks++;
        if (flg !== 4'b0000) begin failures++; $display("FAIL div100_7 flags: got %b expected 0000", flg); end
        checks++;
        if (lat != 9) begin failures++; $display("FAIL div100_7 latency: got %0d expected 9", lat); end
        checks++;
        if (bn != 10) begin failures++; $display("FAIL div100_7 busy cycles: got %0d expected 10", bn); end
        run_op(1'b0, OP_DIV, 8'hC8, 8'd1, res, flg, lat, bn);
        checks++;
        if (res !== 8'hC8 || flg !== 4'b0010) begin
            failures++; $display("FAIL div_c8_1: got %h/%b expected c8/0010", res, flg);
        end
    endtask

    task automatic test_rem();
        logic [7:0] av [2] = '{8'd100, 8'd0};
        logic [7:0] bv [2] = '{8'd7, 8'd5};
        logic [7:0] er [2] = '{8'h02, 8'h00};
        logic [3:0] ef [2] = '{4'b0000, 4'b0001};
        logic [7:0] res; logic [3:0] flg; int lat, bn;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, OP_REM, av[i], bv[i], res, flg, lat, bn);
            checks++;
            if (res !== er[i] || flg !== ef[i]) begin
                failures++;
                $display("FAIL rem_%0d: got %h/%b expected %h/%b", i, res, flg, er[i], ef[i]);
            end
            checks++;
            if (lat != 9) begin failures++; $display("FAIL rem_%0d latency: got %0d expected 9", i, lat); end
        end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] res; logic [3:0] flg; int lat, bn;
        run_op(1'b0, OP_DIV, 8'h2A, 8'h00, res, flg, lat, bn);
        checks++;
        if (res !== 8'hFF || flg !== 4'b0110) begin
            failures++; $display("FAIL div_by_zero: got %h/%b expected ff/0110", res, flg);
        end
        checks++;
        if (lat != 1) begin failures++; $display("FAIL div_by_zero latency: got %0d expected 1", lat); end
        run_op(1'b0, OP_REM, 8'h2A, 8'h00, res, flg, lat, bn);
        checks++;
        if (res !== 8'h2A || flg !== 4'b0100) begin
            failures++; $display("FAIL rem_by_zero: got %h/%b expected 2a/0100", res, flg);
        end
        checks++;
        if (lat != 1) begin failures++; $display("FAIL rem_by_zero latency: got %0d expected 1", lat); end
    endtask

    task automatic test_illegal_opcode();
        logic [7:0] res; logic [3:0] flg; int lat, bn;
        run_op(1'b0, 4'h3, 8'd9, 8'd3, res, flg, lat, bn);
        checks++;
        if (res !== 8'h00 || flg !== 4'b0001 || lat != 1) begin
            failures++;
            $display("FAIL illegal_op: got %h/%b lat %0d expected 00/0001 lat 1", res, flg, lat);
        end
    endtask

    task automatic test_drop_while_busy();
        int got = 0;
        logic [7:0] res = 8'h00;
        @(negedge clk);
        bus_it.data_valid = 1'b1; bus_it.opcode = OP_DIV; bus_it.data_a = 8'd100; bus_it.data_b = 8'd7;
        @(negedge clk);
        bus_it.data_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bus_it.data_valid = (k == 3);
            if (k == 3) begin bus_it.opcode = OP_REM; bus_it.data_a = 8'd50; end
            if (bus_it.result_valid) begin got++; res = bus_it.result; end
            @(negedge clk);
        end
        bus_it.data_valid = 1'b0;
        checks++;
        if (got != 1 || res !== 8'h0E) begin
            failures++; $display("FAIL drop_while_busy: got %0d results last %h expected 1 result 0e",
                                 got, res);
        end
    endtask

    task automatic test_back_to_back();
        int since = 0, nres = 0;
        @(negedge clk);
        bus_it.data_valid = 1'b1; bus_it.opcode = OP_DIV; bus_it.data_a = 8'hFF; bus_it.data_b = 8'h01;
        for (int c = 0; c < 100 && nres < 3; c++) begin
            @(negedge clk);
            since++;
            if (since == 3) begin bus_it.data_a = 8'h10; bus_it.data_b = 8'h03; end
            if (since == 6) begin bus_it.data_a = 8'hFF; bus_it.data_b = 8'h01; end
            if (since == 1) begin
                checks++;
                if (bus_it.busy !== 1'b1) begin
                    failures++; $display("FAIL b2b accept %0d: busy %b expected 1", nres, bus_it.busy);
                end
            end
            if (bus_it.result_valid) begin
                checks++;
                if (bus_it.result !== 8'hFF || bus_it.result_flags !== 4'b0010 || since != 10) begin
                    failures++;
                    $display("FAIL b2b result %0d: got %h/%b gap %0d expected ff/0010 gap 10",
                             nres, bus_it.result, bus_it.result_flags, since);
                end
                nres++;
                since = 0;
                if (nres == 3) bus_it.data_valid = 1'b0;
            end
        end
        checks++;
        if (nres != 3) begin failures++; $display("FAIL b2b count: got %0d expected 3", nres); end
        bus_it.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_it.busy !== 1'b0) begin failures++; $display("FAIL b2b idle: busy %b expected 0", bus_it.busy); end
    endtask

    task automatic test_reset_mid_op();
        int got = 0;
        logic [7:0] res; logic [3:0] flg; int lat, bn;
        @(negedge clk);
        bus_it.data_valid = 1'b1; bus_it.opcode = OP_DIV; bus_it.data_a = 8'd200; bus_it.data_b = 8'd3;
        @(posedge clk);
        #1 bus_it.data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_it.result, bus_it.result_flags, bus_it.result_valid, bus_it.busy} !== 14'h0) begin
            failures++;
            $display("FAIL reset_mid_op outputs: got res=%h flg=%b v=%b busy=%b expected all 0",
                     bus_it.result, bus_it.result_flags, bus_it.result_valid, bus_it.busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus_it.result_valid) got++;
        end
        checks++;
        if (got != 0) begin failures++; $display("FAIL reset_mid_op pulse: got %0d expected 0", got); end
        run_op(1'b0, OP_DIV, 8'd200, 8'd3, res, flg, lat, bn);
        checks++;
        if (res !== 8'h42 || flg !== 4'b0000 || lat != 9) begin
            failures++;
            $display("FAIL after_reset div200_3: got %h/%b lat %0d expected 42/0000 lat 9",
                     res, flg, lat);
        end
    endtask

    task automatic test_iter_random();
        logic [7:0] a, b, res; logic [3:0] op, flg; int lat, bn, exp_lat;
        for (int i = 0; i < 40; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = (i % 10 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_REM;
            exp_lat = (b == 8'h00) ? 1 : 9;
            run_op(1'b0, op, a, b, res, flg, lat, bn);
            checks++;
            if (res !== model_res(op, a, b) || flg !== model_flags(op, a, b) || lat != exp_lat) begin
                failures++;
                $display("FAIL iter_rand op=%h a=%h b=%h: got %h/%b lat %0d expected %h/%b lat %0d",
                         op, a, b, res, flg, lat, model_res(op, a, b), model_flags(op, a, b), exp_lat);
            end
        end
    endtask

    task automatic test_single_cycle_sweep();
        logic [7:0] a, b, res; logic [3:0] op, flg; int lat, bn;
        for (int i = 0; i < 1000; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_REM;
            if (i % 50 == 7) op = 4'h9;
            run_op(1'b1, op, a, b, res, flg, lat, bn);
            checks++;
            if (res !== model_res(op, a, b)) begin
                failures++;
                $display("FAIL sc_result op=%h a=%h b=%h: got %h expected %h",
                         op, a, b, res, model_res(op, a, b));
            end
            checks++;
            if (flg !== model_flags(op, a, b)) begin
                failures++;
                $display("FAIL sc_flags op=%h a=%h b=%h: got %b expected %b",
                         op, a, b, flg, model_flags(op, a, b));
            end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL sc_latency: got %0d expected 1", lat); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus_it.data_valid = 1'b0; bus_it.opcode = 4'h0; bus_it.data_a = 8'h00; bus_it.data_b = 8'h00;
        bus_sc.data_valid = 1'b0; bus_sc.opcode = 4'h0; bus_sc.data_a = 8'h00; bus_sc.data_b = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_div();
        test_rem();
        test_div_by_zero();
        test_illegal_opcode();
        test_drop_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_iter_random();
        test_single_cycle_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_divrem_iter.md
Name: alu_divrem_iter

Overview:
- Multi-cycle divide/remainder execution unit. It sits on the responder side of the ALU top's sub-unit dispatch interface.
- Accepts a start strobe plus opcode and operands from the ALU dispatcher and runs an unsigned restoring division, one quotient bit per cycle.
- Returns a result word, a one-cycle result_valid pulse, and a 4-bit flag vector in the ALU flag bit order.

Parameters:
- SINGLE_CYCLE, 0: 0 = iterative divider, 1 quotient bit per clock; 1 = full combinational array, result registered after 1 clock.
- DATA_WIDTH, 8: operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_valid  input  1  start strobe from the dispatcher; sampled only in IDLE.
- opcode  input  4  4'h6 = DIV (quotient), 4'h7 = REM (remainder); any other value is illegal.
- data_a  input  DATA_WIDTH  dividend, unsigned.
- data_b  input  DATA_WIDTH  divisor, unsigned.
- result  output  DATA_WIDTH  quotient or remainder; held until the next completion.
- result_valid  output  1  one-cycle pulse marking result and result_flags as valid.
- result_flags  output  4  [0] zero, [1] negative, [2] overflow, [3] carry.
- busy  output  1  high from acceptance until the cycle result_valid is asserted, inclusive.

Behaviour:
- Reset (async assert, sync release): state = IDLE; result = 0; result_flags = 0; result_valid = 0; busy = 0; iteration counter = 0.
- Acceptance: on a rising edge in IDLE with data_valid = 1:
  - opcode, data_a and data_b are latched; busy rises.
  - Operands and opcode may change freely after acceptance.
- data_valid is ignored in every state except IDLE. No queueing. A second strobe while busy is dropped.
- States (SINGLE_CYCLE = 0):
  - IDLE -> ITER on acceptance.
  - Divisor = 0, or opcode not 6/7: IDLE -> DONE directly.
  - ITER: restoring step per clock:
    - partial remainder R (DATA_WIDTH+1 bits) = {R, Q_msb} - divisor; if non-negative, keep the difference and shift 1 into Q, else shift 0.
    - Counter runs DATA_WIDTH-1 down to 0. ITER -> DONE after DATA_WIDTH steps.
  - DONE: result/flags are registered; result_valid = 1 for exactly this cycle; busy = 1 this cycle. DONE -> IDLE.
- Latency: result_valid is high in the cycle after edge number N counted from the acceptance edge.
  - N = DATA_WIDTH + 1 for legal non-zero divisors.
  - N = 1 for divide-by-zero or an illegal opcode.
- SINGLE_CYCLE = 1: IDLE -> DONE for all inputs, so N = 1. Results are bit-identical to the iterative mode.
- Results:
  - DIV: result = floor(a/b).
  - REM: result = a mod b.
  - Divide-by-zero: DIV gives all ones, REM gives data_a; overflow flag = 1.
  - Illegal opcode: result = 0, all flags 0 except zero = 1.
- Flags: zero = (result == 0); negative = result[DATA_WIDTH-1]; overflow = 1 only on divide-by-zero; carry = 0 always.
- Back-to-back: DONE -> IDLE costs one cycle. If data_valid is still high in IDLE, a new operation is accepted on that edge (dispatcher's responsibility to drop the strobe).
- Reset mid-operation: the operation is abandoned and result_valid is not pulsed. Outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared ALU package holds:
  - opcode constants DIV = 4'h6, REM = 4'h7;
  - flag index constants ZERO = 0, NEG = 1, OVER = 2, CARRY = 3;
  - a state enum for IDLE/ITER/DONE.
- One sub-module, alu_divrem_step: one combinational restoring step, mapping (R, Q, divisor) to (R', Q').
  - Used once per clock in iterative mode.
  - Chained DATA_WIDTH times via a generate loop for SINGLE_CYCLE = 1.

Test Plan (DATA_WIDTH = 8, SINGLE_CYCLE = 0 unless stated):
- DIV 100/7, one-cycle strobe -> result 0x0E, flags 4'b0000, result_valid high exactly 9 edges after acceptance, busy high for 10 cycles.
- REM 100/7 -> result 0x02; REM 0x00/5 -> result 0x00, flags 4'b0001.
- DIV 0x2A/0 -> result 0xFF, flags 4'b0110, latency 1. REM 0x2A/0 -> result 0x2A, flags 4'b0100.
- Strobe held high continuously with DIV 0xFF/1 -> successive results 0xFF, flags 4'b0010, a new acceptance one cycle after each result_valid. Operand changes while busy do not affect the in-flight result.
- Accept DIV 200/3, assert reset_n low at edge 4 for 2 cycles -> no result_valid, all outputs 0. A fresh 200/3 after release -> 0x42.
- SINGLE_CYCLE = 1: a sweep of 1000 random a/b, including b = 0 -> every result and flag matches the model, latency 1 each.
